multicycle_control: RTL and testbench

Main control state machine of the multi-cycle CPU; sits directly downstream of the instruction register and consumes its opcode field `Instruction[31:26]`. Sequences each instruction through fetch, decode, execute, memory and write-back cycles. Drives every datapath enable and mux select, including `IRWrite` back to the instruction register. Outputs are Moore: decoded from the registered state only.

---
 rtl/mc_ctrl_pkg.sv | 62 ++++++
 rtl/mc_output_decode.sv | 77 +++++++
 rtl/multicycle_control.sv | 93 +++++++++
 tb/tb_multicycle_control.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multi-cycle CPU main control:
//   - state_t  : FSM state encoding (also exported on the debug State port)
//   - OP_*     : opcode field values (Instruction[31:26])
//   - ALUOP_*, SRCB_*, PCSRC_* : datapath select encodings
//   - ctrl_t   : bundle of every control output driven by the FSM
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode
// Purely combinational Moore output decode: state -> control bundle.
// Build option: MC_ADDI_EN compiles in the ADDI_EXEC / ADDI_WB outputs.
// Ports:
//   state : current FSM state (registered)
//   ctrl  : every datapath enable / mux select
module mc_output_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                // Branch target computed speculatively while decoding
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM of the multi-cycle CPU. Holds the state register and
// next-state logic; outputs are Moore, decoded by mc_output_decode.
// Build option: MC_ADDI_EN enables addi (otherwise opcode 001000 traps).
// Ports:
//   clk, rst_n  : clock (rising edge), async active-low reset
//   Op          : opcode from the instruction register
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource :
//                 datapath control
//   Illegal     : one-cycle pulse on an unsupported opcode
//   State       : current state, for debug
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
                    default:      state_d = S_TRAP;
                endcase
            end
            // Only lw/sw reach here, so anything not lw is a store
            S_MEM_ADDR:  state_d = (Op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_R_EXEC:    state_d = S_R_WB;
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: state_d = S_ADDI_WB;
`endif
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    mc_output_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign Illegal     = ctrl.illegal;
    assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Scoreboarded bench for multicycle_control: the driver issues
// instructions and queues the expected per-cycle state/control record
// built from the instruction-level behaviour; a negedge monitor compares.
// Honours MC_ADDI_EN the same way as the design.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Op          (Op),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .Illegal     (Illegal),
        .State       (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observable per-cycle record: state, 1-bit strobes, 2-bit selects, Illegal
    typedef struct packed {
        logic [3:0] st;
        logic [9:0] flags;   // PCW PCWC IorD MR MW IRW M2R RDST RW SRCA
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       ill;
    } rec_t;

    localparam logic [9:0] F_PCW  = 10'b1000000000;
    localparam logic [9:0] F_PCWC = 10'b0100000000;
    localparam logic [9:0] F_IORD = 10'b0010000000;
    localparam logic [9:0] F_MR   = 10'b0001000000;
    localparam logic [9:0] F_MW   = 10'b0000100000;
    localparam logic [9:0] F_IRW  = 10'b0000010000;
    localparam logic [9:0] F_M2R  = 10'b0000001000;
    localparam logic [9:0] F_RDST = 10'b0000000100;
    localparam logic [9:0] F_RW   = 10'b0000000010;
    localparam logic [9:0] F_SRCA = 10'b0000000001;

    rec_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   mon_en   = 0;

    function automatic rec_t mk(input int st, input logic [9:0] f,
                                input logic [1:0] srcb, input logic [1:0] aluop,
                                input logic [1:0] pcsrc, input logic ill);
        rec_t r;
        r.st    = 4'(st);
        r.flags = f;
        r.srcb  = srcb;
        r.aluop = aluop;
        r.pcsrc = pcsrc;
        r.ill   = ill;
        return r;
    endfunction

    function automatic rec_t actual();
        rec_t r;
        r.st    = State;
        r.flags = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA};
        r.srcb  = ALUSrcB;
        r.aluop = ALUOp;
        r.pcsrc = PCSource;
        r.ill   = Illegal;
        return r;
    endfunction

    // Instruction-level reference: the whole cycle-by-cycle story of one
    // instruction, written as the sequence of steps it walks through.
    function automatic void model(input logic [5:0] op, output rec_t seq[$]);
        bit addi_en;
`ifdef MC_ADDI_EN
        addi_en = 1;
`else
        addi_en = 0;
`endif
        seq = {};
        // common fetch + decode
        seq.push_back(mk(0, F_MR | F_IRW | F_PCW, 2'b01, 2'b00, 2'b00, 1'b0));
        seq.push_back(mk(1, 10'b0, 2'b11, 2'b00, 2'b00, 1'b0));
        if (op == 6'b100011) begin          // lw
            seq.push_back(mk(2, F_SRCA, 2'b10, 2'b00, 2'b00, 1'b0));
            seq.push_back(mk(3, F_MR | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0));
            seq.push_back(mk(4, F_RW | F_M2R, 2'b00, 2'b00, 2'b00, 1'b0));
        end else if (op == 6'b101011) begin // sw
            seq.push_back(mk(2, F_SRCA, 2'b10, 2'b00, 2'b00, 1'b0));
            seq.push_back(mk(5, F_MW | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0));
        end else if (op == 6'b000000) begin // R-type
            seq.push_back(mk(6, F_SRCA, 2'b00, 2'b10, 2'b00, 1'b0));
            seq.push_back(mk(7, F_RW | F_RDST, 2'b00, 2'b00, 2'b00, 1'b0));
        end else if (op == 6'b000100) begin // beq
            seq.push_back(mk(8, F_SRCA | F_PCWC, 2'b00, 2'b01, 2'b01, 1'b0));
        end else if (op == 6'b000010) begin // j
            seq.push_back(mk(9, F_PCW, 2'b00, 2'b00, 2'b10, 1'b0));
        end else if (op == 6'b001000 && addi_en) begin
            seq.push_back(mk(10, F_SRCA, 2'b10, 2'b00, 2'b00, 1'b0));
            seq.push_back(mk(11, F_RW, 2'b00, 2'b00, 2'b00, 1'b0));
        end else begin                      // unsupported -> trap
            seq.push_back(mk(12, 10'b0, 2'b00, 2'b00, 2'b00, 1'b1));
        end
    endfunction

    // Op is garbage except where it must be stable: DECODE, and MEM_ADDR for lw/sw
    task automatic run_instr(input logic [5:0] op, input int keep);
        rec_t seq[$];
        int   n;
        bit   memop;
        model(op, seq);
        n     = seq.size();
        if (keep > 0 && keep < n) n = keep;
        for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
        memop = (op == 6'b100011) || (op == 6'b101011);
        Op = 6'($urandom);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (c == 0) Op = op;
            else if (c == 1 && !memop) Op = 6'($urandom);
            else if (c == 2) Op = 6'($urandom);
        end
    endtask

    task automatic check_now(input string name, input rec_t exp);
        rec_t act;
        act = actual();
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every clock cycle with checking enabled presents an output
    always @(negedge clk) begin
        if (mon_en) begin
            rec_t e, a;
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: DUT state %0d with nothing expected", State);
            end else begin
                e = exp_q.pop_front();
                a = actual();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_check @%0t: got %h required %h (state got %0d required %0d)",
                             $time, a, e, a.st, e.st);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [5:0] ops_tbl [6] = '{6'b100011, 6'b101011, 6'b000000,
                                           6'b000100, 6'b000010, 6'b001000};

    initial begin
        rec_t fetch_rec;
        fetch_rec = mk(0, F_MR | F_IRW | F_PCW, 2'b01, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b0;
        Op    = 6'b000000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_now("reset_state", fetch_rec);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1;

        // directed: lw, sw+R back to back, beq, j, illegal, addi
        run_instr(6'b100011, 0);
        run_instr(6'b101011, 0);
        run_instr(6'b000000, 0);
        run_instr(6'b000100, 0);
        run_instr(6'b000010, 0);
        run_instr(6'b111111, 0);
        run_instr(6'b001000, 0);

        // reset in the middle of MEM_READ, held for two cycles
        run_instr(6'b100011, 3);
        check_now("in_mem_read", mk(3, F_MR | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0));
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        check_now("async_reset", fetch_rec);
        repeat (2) begin
            @(posedge clk); #1;
            check_now("held_reset", fetch_rec);
        end
        rst_n  = 1'b1;
        mon_en = 1;
        run_instr(6'b000000, 0);

        // randomized mix: mostly legal opcodes, some arbitrary values
        for (int i = 0; i < 60; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else op = ops_tbl[$urandom_range(0, 5)];
            run_instr(op, 0);
        end

        mon_en = 0;
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
